md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameters: none; operand width fixed at 32 bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  launch request, sampled only when busy=0.
REQ-005 SHALL have port: op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port: a  input  32  operand A (rs value; dividend/multiplicand).
REQ-007 SHALL have port: b  input  32  operand B (rt value; divisor/multiplier).
REQ-008 SHALL have port: mthi  input  1  write wdata to HI.
REQ-009 SHALL have port: mtlo  input  1  write wdata to LO.
REQ-010 SHALL have port: wdata  input  32  data for mthi/mtlo.
REQ-011 SHALL have port: busy  output  1  operation in progress; the controller stalls mfhi/mflo/mult/div while high.
REQ-012 SHALL have port: done  output  1  one-cycle pulse, new HI/LO valid.
REQ-013 SHALL have port: hi  output  32  HI register.
REQ-014 SHALL have port: lo  output  32  LO register.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX; busy=1 exactly in RUN and FIX.
REQ-016 IDLE: start=1 SHALL latch op, a, b and enter RUN at that edge; operands are not re-sampled afterwards.
REQ-017 RUN SHALL last exactly 32 cycles, one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes, counted by a 5-bit counter.
REQ-018 FIX SHALL last one cycle: apply sign correction, write hi/lo at its closing edge, return to IDLE.
REQ-019 done SHALL be 1 only in the first IDLE cycle after FIX, so done rises 34 cycles after the start-sampling edge, with hi/lo already updated.
REQ-020 Multiply: {hi,lo} SHALL equal the full 64-bit product, unsigned for MULTU, two's-complement for MULT.
REQ-021 Divide: lo SHALL be the quotient, hi the remainder; DIV truncates toward zero, remainder takes the dividend's sign.
REQ-022 Divide by zero: lo SHALL be 0xFFFFFFFF, hi SHALL be a unchanged (both DIVU and DIV).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-024 start while busy=1 SHALL be ignored: no restart, no queueing.
REQ-025 mthi/mtlo while busy=0 SHALL update the register at that edge; while busy=1 they SHALL be ignored.
REQ-026 mthi/mtlo in the same cycle as an accepted start SHALL take effect; the operation result later overwrites both registers.
REQ-027 hi/lo SHALL hold their values at all times except under REQ-018, REQ-025 and reset.

Reset
REQ-028 rst=1 SHALL, at the next rising edge, force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, overriding start/mthi/mtlo.
REQ-029 rst during RUN or FIX SHALL abort the operation with no partial result written and no done pulse.

Structure
REQ-030 Op encodings and the state enum SHALL live in shared package md_pkg.
REQ-031 Sign handling (absolute value in, conditional negate out) SHALL be one combinational sub-module md_absneg, instantiated for operand conditioning and for result fix-up.
REQ-032 The datapath SHALL share one 64-bit shift register and one 33-bit adder/subtractor between multiply and divide.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; busy high 33 cycles; done pulses exactly 34 cycles after start.
REQ-034 MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1.
REQ-035 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=0x00000064.
REQ-036 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0x00000000.
REQ-037 mtlo wdata=0x1234 in IDLE -> lo=0x1234 next cycle; mthi and a second start during RUN -> both ignored, first result unchanged.
REQ-038 rst asserted in the 10th RUN cycle of MULTU 7*9 -> next cycle busy=0, hi=lo=0, and no done pulse follows.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and small op-decoding helpers.
package md_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    localparam logic [4:0] LAST_STEP = 5'd31;

    function automatic logic op_is_signed(input md_op_e op_v);
        return (op_v == OP_MULT) || (op_v == OP_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_e op_v);
        return (op_v == OP_DIVU) || (op_v == OP_DIV);
    endfunction

endpackage

// File: rtl/md_absneg.sv
// Conditional two's-complement negate: yields |x| when fed the sign bit,
// or re-applies a sign to an unsigned magnitude on the way out.
module md_absneg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/md_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers: one radix-2
// step per cycle on operand magnitudes, then a single sign fix-up cycle.
module md_unit
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;     // multiplicand (mult) or divisor (div) magnitude
    logic [31:0] a_q, a_d;         // raw dividend, returned as HI on divide-by-zero
    logic        sgn_res_q, sgn_res_d;
    logic        sgn_rem_q, sgn_rem_d;
    logic        bzero_q, bzero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    md_op_e      op_in;
    logic        in_signed;
    logic [31:0] abs_a, abs_b;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic        run_div;
    logic [32:0] add_x, add_y;
    logic        add_cin;
    logic [33:0] add_sum;
    logic [63:0] step;

    assign op_in     = md_op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign run_div   = op_is_div(op_q);

    md_absneg #(.W(32)) u_abs_a    (.val_i(a),            .neg_i(in_signed & a[31]), .val_o(abs_a));
    md_absneg #(.W(32)) u_abs_b    (.val_i(b),            .neg_i(in_signed & b[31]), .val_o(abs_b));
    md_absneg #(.W(64)) u_fix_prod (.val_i(acc_q),        .neg_i(sgn_res_q),         .val_o(prod_fix));
    md_absneg #(.W(32)) u_fix_quo  (.val_i(acc_q[31:0]),  .neg_i(sgn_res_q),         .val_o(quo_fix));
    md_absneg #(.W(32)) u_fix_rem  (.val_i(acc_q[63:32]), .neg_i(sgn_rem_q),         .val_o(rem_fix));

    // Shared 33-bit adder: accumulate multiplicand, or trial-subtract the divisor
    // from the left-shifted partial remainder (carry out = no borrow).
    always_comb begin
        if (run_div) begin
            add_x   = acc_q[63:31];
            add_y   = ~{1'b0, opb_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc_q[63:32]};
            add_y   = acc_q[0] ? {1'b0, opb_q} : 33'd0;
            add_cin = 1'b0;
        end
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {33'd0, add_cin};

    always_comb begin
        if (run_div) begin
            step = add_sum[33] ? {add_sum[31:0], acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        end else begin
            step = {add_sum[32:0], acc_q[31:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        opb_d     = opb_q;
        a_d       = a_q;
        sgn_res_d = sgn_res_q;
        sgn_rem_d = sgn_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    state_d   = RUN;
                    op_d      = op_in;
                    cnt_d     = 5'd0;
                    a_d       = a;
                    bzero_d   = (b == 32'd0);
                    sgn_res_d = in_signed & (a[31] ^ b[31]);
                    sgn_rem_d = in_signed & a[31];
                    if (op_is_div(op_in)) begin
                        acc_d = {32'd0, abs_a};
                        opb_d = abs_b;
                    end else begin
                        acc_d = {32'd0, abs_b};
                        opb_d = abs_a;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!run_div) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (bzero_q) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_MULTU;
            cnt_q     <= 5'd0;
            done_q    <= 1'b0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            a_q       <= 32'd0;
            sgn_res_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            a_q       <= a_d;
            sgn_res_q <= sgn_res_d;
            sgn_rem_q <= sgn_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, randomized ops
// against an arithmetic reference, and hand-written multi-cycle sequences.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    md_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [31:0]     q, r;
        sa = {{32{m_a[31]}}, m_a};
        sb = {{32{m_b[31]}}, m_b};
        ua = {32'd0, m_a};
        ub = {32'd0, m_b};
        case (m_op)
            2'b00: return ua * ub;
            2'b01: return sa * sb;
            2'b10: begin
                if (m_b == 32'd0) return {m_a, 32'hFFFF_FFFF};
                q = 32'(ua / ub);
                r = 32'(ua % ub);
                return {r, q};
            end
            default: begin
                if (m_b == 32'd0) return {m_a, 32'hFFFF_FFFF};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {r, q};
            end
        endcase
    endfunction

    // Drive start during one cycle (cycle 0); returns sampled at cycle 1.
    task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    // Sample cycles k0.. until done; kd = cycle index of done (-1 on timeout).
    task automatic wait_done(input int k0, output int nbusy, output int kd);
        nbusy = 0;
        kd = -1;
        for (int k = k0; k <= 40 && kd < 0; k++) begin
            if (busy) nbusy++;
            if (done) kd = k;
            else tick();
        end
    endtask

    task automatic check_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                            input logic [63:0] exp);
        int nb, kd;
        launch(o, av, bv);
        wait_done(1, nb, kd);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d done_cycle=%0d",
                 o, av, bv, hi, lo, nb, kd);
        check("hi", hi, exp[63:32]);
        check("lo", lo, exp[31:0]);
        check("busy_cycles", 32'(nb), 32'd33);
        check("done_cycle", 32'(kd), 32'd34);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin : main
        int nb, kd, saw_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[7]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // Reset overrides a concurrent mthi/mtlo
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_0001;
        tick();
        check("mthi_idle", hi, 32'hCAFE_0001);
        rst = 1'b1; wdata = 32'hBEEF_0002;
        tick();
        rst = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        $display("reset with mthi/mtlo: hi=%h lo=%h", hi, lo);
        check("reset_over_mthi", hi, 32'd0);
        check("reset_over_mtlo", lo, 32'd0);

        for (int i = 0; i < 11; i++)
            check_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo});

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb = ($urandom_range(0, 6) == 0) ? 32'd0 :
                 ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            check_op(ro, ra, rb, model(ro, ra, rb));
        end

        // mtlo / mthi in IDLE
        @(negedge clk); mtlo = 1'b1; wdata = 32'h0000_1234;
        tick();
        mtlo = 1'b0;
        $display("mtlo 1234: lo=%h", lo);
        check("mtlo_idle", lo, 32'h0000_1234);
        @(negedge clk); mthi = 1'b1; wdata = 32'h0000_5678;
        tick();
        mthi = 1'b0;
        $display("mthi 5678: hi=%h lo=%h", hi, lo);
        check("mthi_idle", hi, 32'h0000_5678);
        check("lo_held", lo, 32'h0000_1234);

        // mthi/mtlo and a second start during RUN are ignored
        launch(2'b00, 32'd6, 32'd7);
        for (int k = 1; k < 5; k++) tick();
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("run_mthi_ignored", hi, 32'h0000_5678);
        check("run_mtlo_ignored", lo, 32'h0000_1234);
        wait_done(6, nb, kd);
        $display("busy start/mthi: hi=%h lo=%h done_cycle=%0d", hi, lo, kd);
        check("restart_done_cycle", 32'(kd), 32'd34);
        check("restart_hi", hi, 32'd0);
        check("restart_lo", lo, 32'd42);
        tick(); tick(); tick();
        check("no_queued_start", {31'd0, busy}, 32'd0);

        // mthi/mtlo alongside an accepted start
        @(negedge clk);
        op = 2'b10; a = 32'd50; b = 32'd7; start = 1'b1;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_0055;
        tick();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("start_mthi", hi, 32'h0000_0055);
        check("start_mtlo", lo, 32'h0000_0055);
        wait_done(1, nb, kd);
        $display("start+mthi/mtlo DIVU 50/7: hi=%h lo=%h", hi, lo);
        check("start_mt_hi_result", hi, 32'd1);
        check("start_mt_lo_result", lo, 32'd7);

        // Reset in the 10th RUN cycle aborts the operation
        launch(2'b00, 32'd7, 32'd9);
        for (int k = 1; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("abort: busy=%0d hi=%h lo=%h", busy, hi, lo);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        saw_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) saw_done++;
            tick();
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_lo_held", lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
